upe_mul_arbiter: RTL and testbench

Shares one upe_mul16uu (16x16 unsigned, combinational, 32-bit product) among NREQ requesters in the uncertainty-propagation datapath. Round-robin arbitration grants at most one operand pair per cycle. Operands are registered, multiplied, and the product is queued in a result FIFO. Each product is returned tagged with the requester index, with valid/ready backpressure.

---
 rtl/upe_mul_arbiter_if.sv | 27 ++
 rtl/upe_mul16uu.sv | 8 +
 rtl/upe_mul_arbiter.sv | 137 +++++++++++++
 tb/tb_upe_mul_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upe_mul_arbiter_if.sv
// Requester/consumer bundle for upe_mul_arbiter.
// The master side drives operands and consumer ready.
// The slave side (the arbiter) drives grants and results.
interface upe_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/upe_mul16uu.sv
// 16x16 unsigned combinational multiplier with a full 32-bit product.
module upe_mul16uu (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = 32'(a) * 32'(b);
endmodule

// File: rtl/upe_mul_arbiter.sv
// Round-robin sharing of one upe_mul16uu among NREQ requesters.
// Granted operands are registered, multiplied, and the tagged product is
// queued in a small result FIFO with valid/ready backpressure.
module upe_mul_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  upe_mul_arbiter_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [IDW-1:0] rr_ptr;
  logic [15:0]    stage_a;
  logic [15:0]    stage_b;
  logic [IDW-1:0] stage_id;
  logic           stage_vld;
  logic [31:0]    product;

  logic [31:0]    mem_data [FIFO_DEPTH];
  logic [IDW-1:0] mem_id   [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [31:0]    last_data;
  logic [IDW-1:0] last_id;

  logic           can_issue;
  logic           xfer;
  logic           push;
  logic           pop;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] sel_id;
  logic [15:0]    sel_a;
  logic [15:0]    sel_b;

  // Credit ignores a same-cycle pop so req_ready never depends on rsp_ready.
  assign can_issue = ({1'b0, count} + {{CW{1'b0}}, stage_vld}) < (CW+1)'(FIFO_DEPTH);

  // Round-robin pick: first valid above rr_ptr, then wrap to the lowest index.
  always_comb begin
    grant  = '0;
    sel_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    xfer   = 1'b0;
    if (RST_N && can_issue) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!xfer && bus.req_valid[i] && (i > 32'(rr_ptr))) begin
          xfer     = 1'b1;
          grant[i] = 1'b1;
          sel_id   = IDW'(i);
          sel_a    = bus.req_a[16*i +: 16];
          sel_b    = bus.req_b[16*i +: 16];
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!xfer && bus.req_valid[i] && (i <= 32'(rr_ptr))) begin
          xfer     = 1'b1;
          grant[i] = 1'b1;
          sel_id   = IDW'(i);
          sel_a    = bus.req_a[16*i +: 16];
          sel_b    = bus.req_b[16*i +: 16];
        end
      end
    end
  end

  assign bus.req_ready = grant;

  // Operand stage and round-robin pointer update on each transfer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr    <= IDW'(NREQ - 1);
      stage_vld <= 1'b0;
      stage_a   <= '0;
      stage_b   <= '0;
      stage_id  <= '0;
    end else begin
      stage_vld <= xfer;
      if (xfer) begin
        rr_ptr   <= sel_id;
        stage_a  <= sel_a;
        stage_b  <= sel_b;
        stage_id <= sel_id;
      end
    end
  end

  upe_mul16uu u_mul (
    .a (stage_a),
    .b (stage_b),
    .p (product)
  );

  assign push = stage_vld;
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wr_ptr] <= product;
      mem_id[wr_ptr]   <= stage_id;
    end
  end

  // FIFO pointers, occupancy and the last-popped value shown when empty.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_data <= '0;
      last_id   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_data <= mem_data[rd_ptr];
        last_id   <= mem_id[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_data  = bus.rsp_valid ? mem_data[rd_ptr] : last_data;
  assign bus.rsp_id    = bus.rsp_valid ? mem_id[rd_ptr]   : last_id;
  assign bus.busy      = stage_vld | (count != '0);
endmodule

// File: tb/tb_upe_mul_arbiter.sv
// Self-checking bench for upe_mul_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_upe_mul_arbiter;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upe_mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  upe_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] d;
    int          id;
  } ent_t;

  // Reference model: queued results, in-flight product, last grant, last pop.
  ent_t        q[$];
  ent_t        infl;
  bit          infl_v;
  int          last_g;
  logic [31:0] last_d;
  int          last_id;

  int n_cmp;
  int n_bad;

  logic [15:0]     opa [NREQ];
  logic [15:0]     opb [NREQ];
  logic [NREQ-1:0] vld;
  logic            rrdy;
  int              g;
  int              ngr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    infl_v  = 1'b0;
    last_g  = NREQ - 1;
    last_d  = '0;
    last_id = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[16*i +: 16] = opa[i];
      bus.req_b[16*i +: 16] = opb[i];
    end
    bus.req_valid = vld;
    bus.rsp_ready = rrdy;
  endtask

  // One clock: drive, check all outputs against the model, advance model.
  task automatic cycle();
    int              exp_g;
    logic [NREQ-1:0] exp_rdy;
    logic            ovf;
    ent_t            tmp;
    drive();
    #1;
    exp_g = -1;
    if (q.size() + int'(infl_v) < DEPTH) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (last_g + k) % NREQ;
        if (exp_g < 0 && vld[j]) exp_g = j;
      end
    end
    exp_rdy = '0;
    if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    g = -1;
    for (int i = 0; i < NREQ; i++)
      if (g < 0 && bus.req_ready[i]) g = i;

    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("rsp_data", bus.rsp_data, q[0].d);
      check_eq("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
    end else begin
      check_eq("rsp_data_hold", bus.rsp_data, last_d);
      check_eq("rsp_id_hold", 32'(bus.rsp_id), 32'(last_id));
    end
    check_eq("busy", 32'(bus.busy), 32'(infl_v || q.size() != 0));
    ovf = dut.stage_vld && (dut.count == DEPTH) && !(bus.rsp_valid && bus.rsp_ready);
    check_eq("no_full_push", 32'(ovf), 32'd0);

    if (q.size() != 0 && rrdy) begin
      tmp     = q.pop_front();
      last_d  = tmp.d;
      last_id = tmp.id;
    end
    if (infl_v) q.push_back(infl);
    infl_v = (exp_g >= 0);
    if (exp_g >= 0) begin
      infl.d  = 32'(opa[exp_g]) * 32'(opb[exp_g]);
      infl.id = exp_g;
      last_g  = exp_g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    vld = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    release_rst();
  endtask

  task automatic drain();
    vld  = '0;
    rrdy = 1'b1;
    repeat (DEPTH + 3) cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rrdy  = 1'b0;
    g     = -1;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    model_reset();

    // Reset state, with every requester asserting valid.
    rst_n = 1'b0;
    vld   = '1;
    drive();
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    release_rst();

    // Single request on requester 0.
    rrdy   = 1'b1;
    vld    = 4'b0001;
    opa[0] = 16'h1234;
    opb[0] = 16'h0010;
    cycle();
    check_eq("single_grant", 32'(g), 32'd0);
    vld = '0;
    cycle();
    check_eq("single_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("single_data", bus.rsp_data, 32'h0001_2340);
    check_eq("single_id", 32'(bus.rsp_id), 32'd0);
    cycle();

    // Operand extremes.
    vld    = 4'b0100;
    opa[2] = 16'hFFFF;
    opb[2] = 16'hFFFF;
    cycle();
    vld    = 4'b0010;
    opa[1] = 16'h0000;
    opb[1] = 16'hBEEF;
    cycle();
    check_eq("max_data", bus.rsp_data, 32'hFFFE_0001);
    check_eq("max_id", 32'(bus.rsp_id), 32'd2);
    vld = '0;
    cycle();
    check_eq("zero_data", bus.rsp_data, 32'd0);
    check_eq("zero_id", 32'(bus.rsp_id), 32'd1);
    drain();

    // Round robin with all requesters continuously valid.
    apply_reset();
    rrdy = 1'b1;
    vld  = '1;
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        opa[r] = 16'($urandom);
        opb[r] = 16'($urandom);
      end
      cycle();
      check_eq("rr_grant", 32'(g), 32'(i % NREQ));
    end
    drain();

    // Backpressure: credit limits grants to the FIFO depth.
    apply_reset();
    rrdy = 1'b0;
    vld  = '1;
    ngr  = 0;
    repeat (7) begin
      cycle();
      if (g >= 0) ngr++;
    end
    check_eq("bp_grants", 32'(ngr), 32'(DEPTH));
    rrdy = 1'b1;
    cycle();
    check_eq("bp_no_grant_on_pop", 32'(g < 0), 32'd1);
    rrdy = 1'b0;
    cycle();
    check_eq("bp_regrant", 32'(g >= 0), 32'd1);
    cycle();
    check_eq("bp_stall", 32'(g < 0), 32'd1);
    drain();

    // Priority pointer: after granting 1, requester 3 wins over 1.
    apply_reset();
    rrdy = 1'b1;
    vld  = 4'b0010;
    cycle();
    check_eq("prio_first", 32'(g), 32'd1);
    vld = 4'b1010;
    cycle();
    check_eq("prio_3", 32'(g), 32'd3);
    vld = 4'b0010;
    cycle();
    check_eq("prio_1", 32'(g), 32'd1);
    drain();

    // Asynchronous reset with three results queued and the stage full.
    apply_reset();
    rrdy = 1'b0;
    vld  = '1;
    repeat (DEPTH) cycle();
    check_eq("ar_stage_full", 32'(dut.stage_vld), 32'd1);
    check_eq("ar_busy_before", 32'(bus.busy), 32'd1);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("ar_busy", 32'(bus.busy), 32'd0);
    check_eq("ar_req_ready", 32'(bus.req_ready), 32'd0);
    release_rst();
    rrdy = 1'b1;
    repeat (3) cycle();
    check_eq("ar_quiet", 32'(bus.rsp_valid), 32'd0);
    vld = '1;
    cycle();
    check_eq("ar_first_grant", 32'(g), 32'd0);
    drain();

    // Random traffic; a requester holds valid and operands until granted.
    apply_reset();
    vld = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!vld[r] && ($urandom % 3 == 0)) begin
          vld[r] = 1'b1;
          case ($urandom % 4)
            0:       opa[r] = 16'h0000;
            1:       opa[r] = 16'hFFFF;
            default: opa[r] = 16'($urandom);
          endcase
          case ($urandom % 4)
            0:       opb[r] = 16'hFFFF;
            1:       opb[r] = 16'h0001;
            default: opb[r] = 16'($urandom);
          endcase
        end
      end
      rrdy = ($urandom % 4) != 0;
      cycle();
      if (g >= 0) vld[g] = 1'b0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
